// File: rtl/frame_serializer_pkg.sv
// frame_serializer_pkg
// Shared constants and types for the frame serializer.
//   WORD_W      : bits per serialized word
//   N_WORDS     : words per packet
//   PKT_W       : total packet width
//   BIT_CNT_W   : width of the within-word bit counter
//   WORD_CNT_W  : width of the word index
//   PKT_IDX_W   : width of a bit index into the whole packet
//   state_t     : serializer FSM states
package frame_serializer_pkg;

  localparam int WORD_W     = 9;
  localparam int N_WORDS    = 3;
  localparam int PKT_W      = WORD_W * N_WORDS;
  localparam int BIT_CNT_W  = $clog2(WORD_W);
  localparam int WORD_CNT_W = $clog2(N_WORDS);
  localparam int PKT_IDX_W  = $clog2(PKT_W);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/frame_serializer.sv
// frame_serializer
// Accepts a packet of N_WORDS words on start_i and shifts it out serially,
// word 0 first and MSB first within each word, one bit per ena_i tick.
// sync_o is low while a word's bits are on sdo_o and high for one tick
// period between words.
// Ports:
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   start_i : one-cycle packet request, honoured only in IDLE
//   data_i  : packet, word k = data_i[k*WORD_W +: WORD_W]
//   ena_i   : bit-rate tick, one clk_i cycle wide
//   sdo_o   : serial data (registered)
//   sync_o  : active-low frame strobe (registered)
//   busy_o  : high from acceptance until done_o (registered)
//   done_o  : one-cycle completion pulse (registered)
module frame_serializer
  import frame_serializer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [PKT_W-1:0] data_i,
  input  logic             ena_i,
  output logic             sdo_o,
  output logic             sync_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t                  state, state_n;
  logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [WORD_CNT_W-1:0]   word_idx, word_idx_n;
  logic [PKT_W-1:0]        pkt, pkt_n;
  logic                    sdo_n, sync_n, busy_n, done_n;

  logic [BIT_CNT_W-1:0]    sel_bit;
  logic [PKT_IDX_W-1:0]    sel_idx;
  logic                    last_bit;
  logic                    last_word;

  assign last_bit  = (bit_cnt == '0);
  assign last_word = (word_idx == WORD_CNT_W'(N_WORDS - 1));

  // The packet register never shifts; the bit presented next is selected
  // from word index and bit counter. In SHIFT it is the next lower bit;
  // entering a word from ARMED or GAP it is that word's MSB.
  always_comb begin
    sel_bit = BIT_CNT_W'(WORD_W - 1);
    if (state == SHIFT && !last_bit) begin
      sel_bit = bit_cnt - BIT_CNT_W'(1);
    end
    sel_idx = PKT_IDX_W'(word_idx) * PKT_IDX_W'(WORD_W) + PKT_IDX_W'(sel_bit);
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    word_idx_n = word_idx;
    pkt_n      = pkt;
    sdo_n      = sdo_o;
    sync_n     = sync_o;
    busy_n     = busy_o;
    done_n     = 1'b0;

    unique case (state)
      IDLE: begin
        // A tick coinciding with acceptance is deliberately not used.
        if (start_i) begin
          pkt_n      = data_i;
          busy_n     = 1'b1;
          bit_cnt_n  = '0;
          word_idx_n = '0;
          state_n    = ARMED;
        end
      end

      ARMED, GAP: begin
        if (ena_i) begin
          sync_n    = 1'b0;
          sdo_n     = pkt[sel_idx];
          bit_cnt_n = BIT_CNT_W'(WORD_W - 1);
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        if (ena_i) begin
          if (!last_bit) begin
            sdo_n     = pkt[sel_idx];
            bit_cnt_n = bit_cnt - BIT_CNT_W'(1);
          end else begin
            sync_n = 1'b1;
            sdo_n  = 1'b0;
            if (!last_word) begin
              word_idx_n = word_idx + WORD_CNT_W'(1);
              state_n    = GAP;
            end else begin
              done_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = IDLE;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_idx <= '0;
      pkt      <= '0;
      sdo_o    <= 1'b0;
      sync_o   <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      word_idx <= word_idx_n;
      pkt      <= pkt_n;
      sdo_o    <= sdo_n;
      sync_o   <= sync_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer
// Directed testbench for frame_serializer: reset, nominal packet, start/tick
// collision, start while busy, back-to-back packets and reset mid-word.
module tb_frame_serializer;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [26:0] data_i;
  logic        ena_i;
  logic        sdo_o;
  logic        sync_o;
  logic        busy_o;
  logic        done_o;

  int passed;
  int total;

  frame_serializer dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .ena_i   (ena_i),
    .sdo_o   (sdo_o),
    .sync_o  (sync_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // One clock edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [26:0] data,
                               input logic ena);
    start_i = start;
    data_i  = data;
    ena_i   = ena;
    cyc();
    start_i = 1'b0;
    ena_i   = 1'b0;
  endtask

  // Expected outputs after tick n of packet pkt, straight from the timing
  // rules: ticks 10/20/30 are word boundaries, otherwise word n/10 bit
  // 9-(n%10) is on the line.
  task automatic checkTick(input int n, input logic [26:0] pkt,
                           input logic done_now);
    logic exp_sdo, exp_sync;
    int   w, b;
    if (n % 10 == 0) begin
      exp_sdo  = 1'b0;
      exp_sync = 1'b1;
    end else begin
      w        = n / 10;
      b        = 9 - (n % 10);
      exp_sdo  = pkt[w * 9 + b];
      exp_sync = 1'b0;
    end
    checkOutput($sformatf("sdo t%0d", n), {31'd0, sdo_o}, {31'd0, exp_sdo});
    checkOutput($sformatf("sync t%0d", n), {31'd0, sync_o}, {31'd0, exp_sync});
    checkOutput($sformatf("busy t%0d", n), {31'd0, busy_o},
                {31'd0, (n < 30)});
    checkOutput($sformatf("done t%0d", n), {31'd0, done_o},
                {31'd0, (done_now && n == 30)});
  endtask

  // Tick n, check, then three quiet cycles and check the outputs held.
  task automatic doTick(input int n, input logic [26:0] pkt);
    applyStimulus(1'b0, 27'h0, 1'b1);
    checkTick(n, pkt, 1'b1);
    if (n != 30) begin
      repeat (3) cyc();
      checkTick(n, pkt, 1'b0);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " sdo"},  {31'd0, sdo_o},  32'd0);
    checkOutput({tag, " sync"}, {31'd0, sync_o}, 32'd1);
    checkOutput({tag, " busy"}, {31'd0, busy_o}, 32'd0);
    checkOutput({tag, " done"}, {31'd0, done_o}, 32'd0);
  endtask

  task automatic checkAccepted(input string tag);
    checkOutput({tag, " busy"}, {31'd0, busy_o}, 32'd1);
    checkOutput({tag, " sync"}, {31'd0, sync_o}, 32'd1);
    checkOutput({tag, " sdo"},  {31'd0, sdo_o},  32'd0);
    checkOutput({tag, " done"}, {31'd0, done_o}, 32'd0);
  endtask

  localparam logic [26:0] PKT_NOM  = 27'b000000011_000000010_000000001;
  localparam logic [26:0] PKT_COL  = 27'b101010101_110011001_100000001;
  localparam logic [26:0] PKT_BUSY = 27'b011110000_100000001_111000111;
  localparam logic [26:0] PKT_B2B  = 27'b110000011_001111100_010101010;
  localparam logic [26:0] PKT_RST  = 27'b100100100_011011011_111111110;

  initial begin
    logic [26:0] captured;
    passed  = 0;
    total   = 0;
    rst_i   = 1'b1;
    start_i = 1'b0;
    data_i  = '0;
    ena_i   = 1'b0;

    // Reset held five cycles with ena toggling.
    for (int i = 0; i < 5; i++) begin
      ena_i = i[0];
      cyc();
      checkIdle($sformatf("reset c%0d", i));
    end
    ena_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) cyc();
    checkIdle("post reset");

    // Nominal packet, capturing sdo on every low-sync tick.
    applyStimulus(1'b1, PKT_NOM, 1'b0);
    checkAccepted("nom accept");
    repeat (3) cyc();
    captured = '0;
    for (int n = 1; n <= 30; n++) begin
      doTick(n, PKT_NOM);
      if (n % 10 != 0) captured[(n / 10) * 9 + 9 - (n % 10)] = sdo_o;
    end
    checkOutput("nom stream", {5'd0, captured}, {5'd0, PKT_NOM});
    cyc();
    checkIdle("nom after done");
    repeat (3) cyc();

    // Start and ena in the same IDLE cycle: the tick is not consumed.
    applyStimulus(1'b1, PKT_COL, 1'b1);
    checkAccepted("col accept");
    repeat (3) cyc();
    checkAccepted("col hold");
    for (int n = 1; n <= 30; n++) doTick(n, PKT_COL);
    cyc();
    checkIdle("col after done");
    repeat (3) cyc();

    // Start with all-ones data at tick 12 must be ignored.
    applyStimulus(1'b1, PKT_BUSY, 1'b0);
    checkAccepted("busy accept");
    repeat (3) cyc();
    for (int n = 1; n <= 12; n++) doTick(n, PKT_BUSY);
    applyStimulus(1'b1, 27'h7FFFFFF, 1'b0);
    checkTick(12, PKT_BUSY, 1'b0);
    data_i = 27'h7FFFFFF;
    for (int n = 13; n <= 30; n++) doTick(n, PKT_BUSY);
    cyc();
    checkIdle("busy after done");
    repeat (3) cyc();

    // Back-to-back: start in the done cycle of PKT_BUSY's successor.
    applyStimulus(1'b1, PKT_NOM, 1'b0);
    repeat (3) cyc();
    for (int n = 1; n <= 30; n++) doTick(n, PKT_NOM);
    applyStimulus(1'b1, PKT_B2B, 1'b0);
    checkAccepted("b2b accept");
    repeat (3) cyc();
    for (int n = 1; n <= 30; n++) doTick(n, PKT_B2B);
    cyc();
    checkIdle("b2b after done");
    repeat (3) cyc();

    // Reset after tick 15, then ticks must not produce anything.
    applyStimulus(1'b1, PKT_COL, 1'b0);
    repeat (3) cyc();
    for (int n = 1; n <= 15; n++) doTick(n, PKT_COL);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    checkIdle("rst mid");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 27'h0, 1'b1);
      checkIdle($sformatf("rst idle %0d", i));
      repeat (3) cyc();
    end

    // Fresh packet after the aborted one starts from word 0.
    applyStimulus(1'b1, PKT_RST, 1'b0);
    checkAccepted("rst2 accept");
    repeat (3) cyc();
    for (int n = 1; n <= 30; n++) doTick(n, PKT_RST);
    cyc();
    checkIdle("rst2 after done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
